// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the binary-to-BCD converter.
package bcd_pkg;

  localparam int DIGIT_W        = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Largest value representable in the given number of BCD digits (10^digits - 1).
  function automatic int bcd_max(input int digits);
    int m;
    m = 1;
    for (int i = 0; i < digits; i++) begin
      m = m * 10;
    end
    return m - 1;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the left shift.
import bcd_pkg::*;

module bcd_add3_digit (
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= DIGIT_W'(BCD_ADJ_THRESH)) begin
      digit_out = digit_in + DIGIT_W'(BCD_ADJ);
    end
  end

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock, start/busy/done handshake.
// Optional BIN2BCD_SAT_EN: out-of-range operands saturate to all 9s and raise ovf.
import bcd_pkg::*;

module bin_to_bcd_converter #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      ovf
);

  localparam int BCD_W       = DIGIT_W * DIGITS;
  localparam int WORK_DIGITS = DIGITS + 1;
  localparam int WORK_W      = DIGIT_W * WORK_DIGITS;
  localparam int CNT_W       = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIN_W-1:0]     shift_q;
  logic [BIN_W-1:0]     shift_next;
  logic [WORK_W-1:0]    work_q;
  logic [WORK_W-1:0]    work_adj;
  logic [WORK_W-1:0]    work_next;
  logic                 last_shift;
  logic                 unused_adj_msb;

  // Extra working digit absorbs out-of-range bits so they never disturb the kept digits.
  for (genvar g = 0; g < WORK_DIGITS; g++) begin : g_adj
    bcd_add3_digit u_add3 (
      .digit_in  (work_q[g*DIGIT_W +: DIGIT_W]),
      .digit_out (work_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign {work_next, shift_next} = {work_adj[WORK_W-2:0], shift_q, 1'b0};
  assign unused_adj_msb          = work_adj[WORK_W-1];
  assign last_shift              = (cnt_q == '0);

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BIN2BCD_SAT_EN
  localparam logic [31:0] BCD_MAX_U = 32'(bcd_max(DIGITS));

  logic ovf_pend_q;
  logic ovf_q;

  assign ovf = ovf_q;

  // Range is judged on the operand as captured; the shift register is consumed by the conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        ovf_pend_q <= (32'(bin_in) > BCD_MAX_U);
      end
      if (state_q == SHIFT && last_shift) begin
        ovf_q <= ovf_pend_q;
      end
    end
  end
`else
  assign ovf = 1'b0;
`endif

  // Capture in IDLE, one double-dabble step per SHIFT cycle, result latched on the last shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      work_q  <= '0;
      bcd_out <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q <= bin_in;
            work_q  <= '0;
            cnt_q   <= CNT_W'(BIN_W - 1);
          end
        end
        SHIFT: begin
          shift_q <= shift_next;
          work_q  <= work_next;
          if (!last_shift) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
`ifdef BIN2BCD_SAT_EN
            bcd_out <= ovf_pend_q ? {DIGITS{4'h9}} : work_next[BCD_W-1:0];
`else
            bcd_out <= work_next[BCD_W-1:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed self-checking bench for bin_to_bcd_converter (default build, or with BIN2BCD_SAT_EN).
module tb_bin_to_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;

  int tests;
  int failed;

  bin_to_bcd_converter #(.BIN_W(14), .DIGITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the first falling edge after the accepting edge.
  task automatic wait_done(input string tag, input logic [15:0] exp_bcd, input logic exp_ovf);
    int n;
    int bcyc;
    n    = 1;
    bcyc = busy ? 1 : 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) bcyc++;
    end
    check({tag, "_latency"}, n, 15);
    check({tag, "_busy_cycles"}, bcyc, 15);
    check({tag, "_bcd"}, {16'h0, bcd_out}, {16'h0, exp_bcd});
    check({tag, "_ovf"}, {31'h0, ovf}, {31'h0, exp_ovf});
    @(negedge clk);
    check({tag, "_done_pulse"}, {30'h0, busy, done}, 32'h0);
    check({tag, "_hold"}, {16'h0, bcd_out}, {16'h0, exp_bcd});
  endtask

  task automatic convert(input string tag, input logic [13:0] v,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    wait_done(tag, exp_bcd, exp_ovf);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {15'h0, busy, done, ovf, bcd_out}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {30'h0, busy, done}, 32'h0);

    convert("c1234", 14'd1234, 16'h1234, 1'b0);
    convert("c0", 14'd0, 16'h0000, 1'b0);
    convert("c9999", 14'd9999, 16'h9999, 1'b0);
`ifdef BIN2BCD_SAT_EN
    convert("c10000", 14'd10000, 16'h9999, 1'b1);
    convert("c16383", 14'd16383, 16'h9999, 1'b1);
`else
    convert("c10000", 14'd10000, 16'h0000, 1'b0);
    convert("c16383", 14'd16383, 16'h6383, 1'b0);
`endif
    convert("c5", 14'd5, 16'h0005, 1'b0);

    // Start held high through the conversion; 77 must only be taken after returning to IDLE.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd42;
    @(negedge clk);
    bin_in = 14'd77;
    wait_done("c42_held", 16'h0042, 1'b0);
    @(negedge clk);
    check("c77_reaccepted_busy", {31'h0, busy}, 32'h1);
    check("c77_old_result_kept", {16'h0, bcd_out}, 32'h0042);
    start = 1'b0;
    wait_done("c77", 16'h0077, 1'b0);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd5678;
    @(negedge clk);
    start  = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy_before_reset", {31'h0, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1 check("reset_mid_conv", {15'h0, busy, done, ovf, bcd_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    convert("c321", 14'd321, 16'h0321, 1'b0);

    // Back-to-back: new start in the first IDLE cycle after DONE.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd9;
    @(negedge clk);
    start  = 1'b0;
    begin : b2b
      int n;
      n = 1;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("c9_latency", n, 15);
      check("c9_bcd", {16'h0, bcd_out}, 32'h0009);
    end
    @(negedge clk);
    check("c9_idle", {30'h0, busy, done}, 32'h0);
    start  = 1'b1;
    bin_in = 14'd8765;
    @(negedge clk);
    start  = 1'b0;
    check("c8765_accepted", {31'h0, busy}, 32'h1);
    repeat (6) @(negedge clk);
    check("c9_stable_during_busy", {16'h0, bcd_out}, 32'h0009);
    bin_in = 14'd1111;
    repeat (8) @(negedge clk);
    check("c8765_done", {31'h0, done}, 32'h1);
    check("c8765_bcd", {16'h0, bcd_out}, 32'h8765);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
